// File: rtl/ids_pattern_match_pkg.sv
// ids_pattern_match_pkg: shared ctrl codes, packet state encoding and last-word byte-valid helper
package ids_pattern_match_pkg;
    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;
    localparam logic [7:0] CTRL_PAYLOAD = 8'h00;
    localparam int PAT_W = 56;
    localparam int MASK_W = 7;
    localparam int SRCH_W = 112;
    typedef enum logic {S_HDR, S_PAY} state_t;
    function automatic logic [3:0] valid_bytes(input logic [7:0] ctrl);
        logic [3:0] n;
        n = 4'd8;
        for (int p = 7; p >= 0; p--)
            if (ctrl[p]) n = 4'(8 - p);
        return n;
    endfunction
endpackage

// File: rtl/ids_skid_fifo.sv
// ids_skid_fifo: 2-entry fall-through skid buffer with registered ready
module ids_skid_fifo #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         in_rdy,
    input  logic         out_rdy,
    output logic         out_wr,
    output logic [W-1:0] out_data
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_q, rd_d, wr_q, wr_d, rdy_q, rdy_d, pop;
    logic [1:0]   cnt_q, cnt_d;
    always_comb begin
        pop = (cnt_q != 2'd0) && out_rdy;
        mem_d = mem_q;
        if (push) mem_d[wr_q] = push_data;
        wr_d = wr_q ^ push;
        rd_d = rd_q ^ pop;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        rdy_d = cnt_d != 2'd2;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
            rdy_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end
    assign in_rdy   = rdy_q;
    assign out_wr   = pop;
    assign out_data = mem_q[rd_q];
endmodule

// File: rtl/ids_pattern_match.sv
// ids_pattern_match: 1-cycle pass-through stage counting packets whose payload holds a masked 7-byte pattern
module ids_pattern_match
    import ids_pattern_match_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic [PAT_W-1:0]      pattern,
    input  logic [MASK_W-1:0]     pattern_mask,
    input  logic                  match_en,
    output logic [CNT_WIDTH-1:0]  match_cnt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);
    state_t                state_q, state_d;
    logic [PAT_W-1:0]      pat_q, pat_d, pat_e, win_q, win_d;
    logic [MASK_W-1:0]     mask_q, mask_d, mask_e;
    logic                  en_q, en_d, hit_seen_q, hit_seen_d;
    logic [CNT_WIDTH-1:0]  match_cnt_q, match_cnt_d, pkt_cnt_q, pkt_cnt_d;
    logic                  acc, first, pay, last, hit, ok;
    logic [SRCH_W-1:0]     win;
    logic [3:0]            nvalid;
    logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_out;
    always_comb begin
        acc = in_wr && in_rdy;
        first = state_q == S_HDR;
        pay = acc && (!first || in_ctrl == CTRL_PAYLOAD);
        last = acc && !first && in_ctrl != CTRL_PAYLOAD;
        pat_e = first ? pattern : pat_q;
        mask_e = first ? pattern_mask : mask_q;
        // Current byte 7 is only reachable by the next word's offsets, so it is left out here.
        win = {win_q & {PAT_W{!first}}, in_data[DATA_WIDTH-1:8]};
        nvalid = last ? valid_bytes(in_ctrl[7:0]) : 4'd8;
        hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ok = 1'b1;
            for (int i = 0; i < 7; i++) begin
                if ((k + i < 7) ? first : (k + i - 7 >= int'(nvalid))) ok = 1'b0;
                if (mask_e[6 - i] && win[SRCH_W - 1 - 8 * (k + i) -: 8] != pat_e[PAT_W - 1 - 8 * i -: 8]) ok = 1'b0;
            end
            hit = hit | ok;
        end
        state_d = state_q;
        pat_d = pat_q;
        mask_d = mask_q;
        en_d = en_q;
        hit_seen_d = hit_seen_q;
        win_d = win_q;
        pkt_cnt_d = pkt_cnt_q;
        match_cnt_d = match_cnt_q;
        if (pay) begin
            win_d = in_data[PAT_W-1:0];
            hit_seen_d = (hit_seen_q && !first) || hit;
            if (first) begin
                state_d = S_PAY;
                pat_d = pattern;
                mask_d = pattern_mask;
                en_d = match_en;
            end
        end
        if (last) begin
            state_d = S_HDR;
            hit_seen_d = 1'b0;
            win_d = '0;
            pkt_cnt_d = &pkt_cnt_q ? pkt_cnt_q : pkt_cnt_q + 1'b1;
            if (en_q && (hit_seen_q || hit))
                match_cnt_d = &match_cnt_q ? match_cnt_q : match_cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_HDR;
            pat_q       <= '0;
            mask_q      <= '0;
            en_q        <= 1'b0;
            hit_seen_q  <= 1'b0;
            win_q       <= '0;
            pkt_cnt_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            mask_q      <= mask_d;
            en_q        <= en_d;
            hit_seen_q  <= hit_seen_d;
            win_q       <= win_d;
            pkt_cnt_q   <= pkt_cnt_d;
            match_cnt_q <= match_cnt_d;
        end
    end
    ids_skid_fifo #(.W(DATA_WIDTH + CTRL_WIDTH)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (acc),
        .push_data({in_ctrl, in_data}),
        .in_rdy   (in_rdy),
        .out_rdy  (out_rdy),
        .out_wr   (out_wr),
        .out_data (fifo_out)
    );
    assign out_ctrl  = fifo_out[DATA_WIDTH+CTRL_WIDTH-1:DATA_WIDTH];
    assign out_data  = fifo_out[DATA_WIDTH-1:0];
    assign pkt_cnt   = pkt_cnt_q;
    assign match_cnt = match_cnt_q;
endmodule
